// File: rtl/lh_pkg.sv
// Shared widths, ASCII constants and FSM state type for the digest hex serializer.
package lh_pkg;

    localparam int unsigned DIGEST_W  = 64;
    localparam int unsigned N_NIBBLES = 16;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned CNT_W     = $clog2(N_NIBBLES);
    localparam int unsigned CHAR_W    = 8;

    localparam logic [CHAR_W-1:0] ASCII_NL   = 8'h0A;
    localparam logic [CHAR_W-1:0] ASCII_0    = 8'h30;
    localparam logic [CHAR_W-1:0] ASCII_A_LC = 8'h61;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEX  = 2'd1,
        NL   = 2'd2
    } state_t;

endpackage

// File: rtl/lh_nibble_to_hex.sv
// Combinational nibble to lowercase ASCII hex digit.
module lh_nibble_to_hex
    import lh_pkg::*;
(
    input  logic [NIB_W-1:0]  nib,
    output logic [CHAR_W-1:0] ascii_c
);

    always_comb begin
        if (nib < NIB_W'(10)) begin
            ascii_c = ASCII_0 + CHAR_W'(nib);
        end else begin
            ascii_c = ASCII_A_LC + CHAR_W'(nib - NIB_W'(10));
        end
    end

endmodule

// File: rtl/lh_digest_hex_ser.sv
// Serializes a 64-bit digest as 16 lowercase hex characters (plus optional newline)
// over a valid/ready character stream; overrun of a busy frame is flagged, not queued.
module lh_digest_hex_ser
    import lh_pkg::*;
#(
    parameter bit APPEND_NEWLINE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIGEST_W-1:0] digest_in,
    input  logic                digest_valid,
    output logic [CHAR_W-1:0]   out_char,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                err_overrun,
    input  logic                err_clear
);

    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(N_NIBBLES - 1);

    state_t              state, state_nxt;
    logic [DIGEST_W-1:0] sreg, sreg_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                err_nxt;
    logic                xfer_c, frame_end_c, overrun_c;
    logic [CHAR_W-1:0]   hex_c, char_nxt;
    logic                last_nxt, valid_nxt;

    // Encoder looks at the next MS nibble so out_char can be registered.
    lh_nibble_to_hex u_hex (
        .nib     (sreg_nxt[DIGEST_W-1 -: NIB_W]),
        .ascii_c (hex_c)
    );

    // State register; all outputs are flops loaded from next-cycle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sreg        <= '0;
            cnt         <= '0;
            err_overrun <= 1'b0;
            out_char    <= '0;
            out_last    <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            sreg        <= sreg_nxt;
            cnt         <= cnt_nxt;
            err_overrun <= err_nxt;
            out_char    <= char_nxt;
            out_last    <= last_nxt;
            out_valid   <= valid_nxt;
            busy        <= valid_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;

        xfer_c      = (state != IDLE) && out_ready;
        frame_end_c = xfer_c && ((state == NL) ||
                                 (state == HEX && cnt == LAST_NIB && !APPEND_NEWLINE));
        overrun_c   = digest_valid && (state != IDLE) && !frame_end_c;

        case (state)
            IDLE: begin
                if (digest_valid) begin
                    sreg_nxt  = digest_in;
                    cnt_nxt   = '0;
                    state_nxt = HEX;
                end
            end
            HEX: begin
                if (xfer_c) begin
                    sreg_nxt = sreg << NIB_W;
                    cnt_nxt  = CNT_W'(cnt + 1'b1);
                    if (cnt == LAST_NIB) begin
                        if (APPEND_NEWLINE) state_nxt = NL;
                        else                state_nxt = IDLE;
                    end
                end
            end
            NL: begin
                if (xfer_c) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Frame end doubles as an accept slot for a back-to-back digest.
        if (frame_end_c) begin
            if (digest_valid) begin
                sreg_nxt  = digest_in;
                cnt_nxt   = '0;
                state_nxt = HEX;
            end else begin
                sreg_nxt  = '0;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        end

        err_nxt = overrun_c || (err_overrun && !err_clear);
    end

    // Output logic for the cycle after this edge.
    always_comb begin
        char_nxt  = '0;
        last_nxt  = 1'b0;
        valid_nxt = (state_nxt != IDLE);
        case (state_nxt)
            HEX: begin
                char_nxt = hex_c;
                last_nxt = !APPEND_NEWLINE && (cnt_nxt == LAST_NIB);
            end
            NL: begin
                char_nxt = ASCII_NL;
                last_nxt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/lh_digest_hex_ser.md
LH_DIGEST_HEX_SER -- requirements
Module: lh_digest_hex_ser

Interface
REQ-001 SHALL have parameter APPEND_NEWLINE, default 1, meaning a 0x0A character follows the 16 hex characters of each digest.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port digest_in  input  64  digest from the light-hash core, bits [63:56] = H[0].
REQ-005 SHALL have port digest_valid  input  1  single-cycle strobe: digest_in is valid this cycle (the core's digest_ready).
REQ-006 SHALL have port out_char  output  8  ASCII character to the downstream consumer.
REQ-007 SHALL have port out_valid  output  1  out_char is valid.
REQ-008 SHALL have port out_ready  input  1  consumer accepts out_char; transfer occurs when out_valid && out_ready.
REQ-009 SHALL have port out_last  output  1  marks the final character of a digest frame.
REQ-010 SHALL have port busy  output  1  a frame is in progress (state not IDLE).
REQ-011 SHALL have port err_overrun  output  1  sticky flag: a digest was dropped.
REQ-012 SHALL have port err_clear  input  1  synchronous clear of err_overrun.

Function
REQ-013 SHALL implement FSM states IDLE, HEX, NL; reset state IDLE.
REQ-014 In IDLE with digest_valid=1, SHALL capture digest_in into a 64-bit shift register, clear the nibble counter to 0 and enter HEX.
- Latency: first character is presented with out_valid=1 in the cycle after the strobe.
REQ-015 In HEX, out_char SHALL be the hex encoding of shift register bits [63:60], MS nibble first.
- Encoding: 0-9 map to 0x30-0x39; 10-15 map to lowercase 0x61-0x66.
REQ-016 On each HEX transfer, SHALL shift the register left by 4 and increment the 4-bit nibble counter.
REQ-017 On the transfer with counter=15, SHALL go to NL if APPEND_NEWLINE=1, otherwise end the frame.
REQ-018 In NL, SHALL present out_char=0x0A with out_valid=1; the transfer ends the frame.
REQ-019 out_last SHALL be 1 only with the final character of the frame: the NL character, or the 16th hex character when APPEND_NEWLINE=0.
REQ-020 While out_valid=1 && out_ready=0, out_char, out_last and all internal state SHALL hold stable.
REQ-021 At frame end with digest_valid=0, SHALL return to IDLE with out_valid=0 in the next cycle.
REQ-022 At frame end with digest_valid=1 in the same cycle, SHALL capture the new digest and re-enter HEX (back-to-back, no bubble, no error).
REQ-023 A digest_valid at any other non-IDLE cycle SHALL be dropped and SHALL set err_overrun=1 in the next cycle; the current frame continues unaffected.
REQ-024 err_overrun SHALL clear only on err_clear=1 or reset; if set and clear coincide, set SHALL win.
REQ-025 busy SHALL equal (state != IDLE); out_valid SHALL equal busy.

Reset
REQ-026 Asynchronous assertion of rst_n=0 SHALL immediately force: state IDLE, out_valid=0, out_char=0x00, out_last=0, busy=0, err_overrun=0, shift register and counter 0.
REQ-027 Reset mid-frame SHALL abandon the frame; no residual characters SHALL appear after release.
REQ-028 After rst_n deasserts, the first digest_valid SHALL be accepted on the next rising edge.

Structure
REQ-029 Package lh_pkg SHALL hold: DIGEST_W=64, N_NIBBLES=16, ASCII_NL=8'h0A, ASCII_0=8'h30, ASCII_A_LC=8'h61, and the FSM state enum.
REQ-030 SHALL instantiate one combinational sub-module, lh_nibble_to_hex (4-bit in, 8-bit ASCII out), shared by the hex datapath.

Verification
REQ-031 Basic frame: digest 64'h0123456789ABCDEF, out_ready=1, APPEND_NEWLINE=1 -> "0123456789abcdef" then 0x0A over 17 consecutive cycles starting 1 cycle after the strobe; out_last only on 0x0A.
REQ-032 Backpressure: digest 64'hFFFF0000A5A5C3C3 with out_ready toggled pseudo-randomly -> "ffff0000a5a5c3c3\n"; out_char stable on every stalled cycle.
REQ-033 Overrun: a second strobe at character 5 of a frame -> err_overrun=1 next cycle, first frame intact, second digest never emitted; err_clear -> 0.
REQ-034 Back-to-back: second strobe exactly on the 0x0A transfer -> second frame starts next cycle, no idle cycle, err_overrun stays 0.
REQ-035 Reset mid-frame: rst_n=0 at character 8 -> all outputs 0 immediately; after release a new digest 64'h0 -> "0000000000000000\n".
REQ-036 APPEND_NEWLINE=0: digest 64'hDEADBEEFCAFEF00D -> "deadbeefcafef00d" with out_last on the final 'd'; next cycle out_valid=0.
